jstk_scheduler: RTL and testbench

JSTK_SCHEDULER -- requirements
Module: jstk_scheduler

---
 rtl/jstk_pkg.sv | 37 +++
 rtl/interval_timer.sv | 27 ++
 rtl/jstk_scheduler.sv | 133 +++++++++++++
 tb/tb_jstk_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK poll/LED scheduler: FSM encoding, command base
// and the bit positions of the fields in the 40-bit DOUT word.
package jstk_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_XFER    = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    localparam logic [7:0] CMD_BASE = 8'h80;

    localparam int unsigned X_LO_MSB = 39;
    localparam int unsigned X_LO_LSB = 32;
    localparam int unsigned X_HI_MSB = 25;
    localparam int unsigned X_HI_LSB = 24;
    localparam int unsigned Y_LO_MSB = 23;
    localparam int unsigned Y_LO_LSB = 16;
    localparam int unsigned Y_HI_MSB = 9;
    localparam int unsigned Y_HI_LSB = 8;
    localparam int unsigned BTN_MSB  = 2;
    localparam int unsigned BTN_LSB  = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
    } jstk_sample_t;

    function automatic jstk_sample_t decode_dout(input logic [39:0] dout);
        jstk_sample_t s;
        s.x   = {dout[X_HI_MSB:X_HI_LSB], dout[X_LO_MSB:X_LO_LSB]};
        s.y   = {dout[Y_HI_MSB:Y_HI_LSB], dout[Y_LO_MSB:Y_LO_LSB]};
        s.btn = dout[BTN_MSB:BTN_LSB];
        return s;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Free-running interval counter: o_done pulses on the enabled cycle the count sits at
// TERMINAL-1, after which the count wraps to 0. Clear has priority over enable.
module interval_timer #(
    parameter int unsigned TERMINAL = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam int unsigned CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_done = i_enable && (r_count == CNT_W'(TERMINAL - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_done ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/jstk_scheduler.sv
// Schedules PmodJSTK transfers: periodic position polls and on-demand LED updates,
// one transaction at a time, latching the decoded DOUT sample at the end of each transfer.
module jstk_scheduler
    import jstk_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 20_000_000,
    parameter int unsigned XFER_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_en,
    input  logic        led_req,
    input  logic [1:0]  led_val,
    input  logic [39:0] jstk_dout,
    output logic        snd_rec,
    output logic [7:0]  snd_data,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [2:0]  btn,
    output logic        data_valid,
    output logic        led_ack,
    output logic        busy
);

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic         r_led_pending;
    logic [1:0]   r_led_buf;
    logic [1:0]   r_led_cmd;
    logic         r_is_led;
    logic         r_poll_pending;
    logic [7:0]   r_snd_data;
    jstk_sample_t r_sample;

    logic         w_poll_done;
    logic         w_xfer_done;
    logic         w_idle;
    logic         w_led_accept;
    logic         w_led_go;
    logic         w_poll_go;
    logic         w_start;
    logic [1:0]   w_led_sel;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_led_accept = led_req && !r_led_pending;
    // A request or timer tick landing in the deciding IDLE cycle counts as pending, so
    // it is served (or absorbed) by the transaction that starts now.
    assign w_led_go     = r_led_pending || w_led_accept;
    assign w_poll_go    = r_poll_pending || w_poll_done;
    assign w_start      = w_idle && (w_led_go || w_poll_go);
    assign w_led_sel    = r_led_pending ? r_led_buf : led_val;

    interval_timer #(
        .TERMINAL (POLL_PERIOD)
    ) u_poll_timer (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clear  (!poll_en || w_start),
        .i_enable (poll_en),
        .o_done   (w_poll_done)
    );

    interval_timer #(
        .TERMINAL (XFER_CYCLES)
    ) u_xfer_timer (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clear  (r_state != ST_XFER),
        .i_enable (r_state == ST_XFER),
        .o_done   (w_xfer_done)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_state_next = ST_START;
            ST_START:   w_state_next = ST_XFER;
            ST_XFER:    if (w_xfer_done) w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_led_pending  <= 1'b0;
            r_led_buf      <= 2'b00;
            r_led_cmd      <= 2'b00;
            r_is_led       <= 1'b0;
            r_poll_pending <= 1'b0;
            r_snd_data     <= 8'h00;
            r_sample       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_led_pending  <= 1'b0;
                r_poll_pending <= 1'b0;
                r_is_led       <= w_led_go;
                if (w_led_go) begin
                    r_led_cmd  <= w_led_sel;
                    r_snd_data <= CMD_BASE | {6'b0, w_led_sel};
                end else begin
                    r_snd_data <= CMD_BASE | {6'b0, r_led_cmd};
                end
            end else begin
                if (w_led_accept) begin
                    r_led_pending <= 1'b1;
                    r_led_buf     <= led_val;
                end
                if (!poll_en) begin
                    r_poll_pending <= 1'b0;
                end else if (w_poll_done) begin
                    r_poll_pending <= 1'b1;
                end
            end
            // Latch on the last XFER cycle so the sample is visible alongside data_valid.
            if (r_state == ST_XFER && w_xfer_done) begin
                r_sample <= decode_dout(jstk_dout);
            end
        end
    end

    assign snd_rec    = (r_state == ST_START);
    assign snd_data   = r_snd_data;
    assign pos_x      = r_sample.x;
    assign pos_y      = r_sample.y;
    assign btn        = r_sample.btn;
    assign data_valid = (r_state == ST_CAPTURE);
    assign led_ack    = data_valid && r_is_led;
    assign busy       = !w_idle;

endmodule

// File: tb/tb_jstk_scheduler.sv
// Self-checking bench for jstk_scheduler: a cycle-count transaction model checked every
// cycle, plus directed scenarios with hand-computed timing and field values.
module tb_jstk_scheduler;

    localparam int P = 20;
    localparam int X = 8;

    logic        clk;
    logic        rst;
    logic        poll_en;
    logic        led_req;
    logic [1:0]  led_val;
    logic [39:0] jstk_dout;
    logic        snd_rec;
    logic [7:0]  snd_data;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [2:0]  btn;
    logic        data_valid;
    logic        led_ack;
    logic        busy;

    jstk_scheduler #(
        .POLL_PERIOD (P),
        .XFER_CYCLES (X)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .poll_en    (poll_en),
        .led_req    (led_req),
        .led_val    (led_val),
        .jstk_dout  (jstk_dout),
        .snd_rec    (snd_rec),
        .snd_data   (snd_data),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .btn        (btn),
        .data_valid (data_valid),
        .led_ack    (led_ack),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rec    = 0;
    int n_dv     = 0;
    int n_ack    = 0;
    bit model_ok = 1'b0;

    // Model: m_age is cycles since START (-1 when idle).
    int         m_age = -1;
    bit         m_is_led;
    int         m_poll_cnt;
    bit         m_poll_pend;
    bit         m_led_pend;
    logic [1:0] m_led_buf;
    logic [1:0] m_led_last;
    logic [7:0] m_snd_data;
    logic [9:0] m_pos_x;
    logic [9:0] m_pos_y;
    logic [2:0] m_btn;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model, advanced on every rising edge from the inputs of the ending cycle.
    initial begin
        bit led_acc;
        bit poll_hit;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_age = -1; m_is_led = 0; m_poll_cnt = 0; m_poll_pend = 0; m_led_pend = 0;
                m_led_buf = 0; m_led_last = 0; m_snd_data = 0;
                m_pos_x = 0; m_pos_y = 0; m_btn = 0;
                model_ok = 1'b1;
            end else begin
                led_acc  = led_req && !m_led_pend;
                poll_hit = poll_en && (m_poll_cnt == P - 1);
                if (m_age < 0 && (m_led_pend || led_acc || m_poll_pend || poll_hit)) begin
                    m_is_led = m_led_pend || led_acc;
                    if (m_is_led) m_led_last = m_led_pend ? m_led_buf : led_val;
                    m_snd_data  = 8'h80 | {6'b0, m_led_last};
                    m_led_pend  = 0;
                    m_poll_pend = 0;
                    m_poll_cnt  = 0;
                    m_age       = 0;
                end else begin
                    if (led_acc) begin
                        m_led_pend = 1;
                        m_led_buf  = led_val;
                    end
                    if (!poll_en) begin
                        m_poll_cnt = 0; m_poll_pend = 0;
                    end else if (poll_hit) begin
                        m_poll_cnt = 0; m_poll_pend = 1;
                    end else begin
                        m_poll_cnt++;
                    end
                    if (m_age == X) begin
                        m_pos_x = {jstk_dout[25:24], jstk_dout[39:32]};
                        m_pos_y = {jstk_dout[9:8], jstk_dout[23:16]};
                        m_btn   = jstk_dout[2:0];
                    end
                    if (m_age == X + 1) m_age = -1;
                    else if (m_age >= 0) m_age++;
                end
            end
        end
    end

    // Compare process: every cycle after the first reset edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("snd_rec",    64'(snd_rec),    64'(m_age == 0));
                check("busy",       64'(busy),       64'(m_age >= 0));
                check("data_valid", 64'(data_valid), 64'(m_age == X + 1));
                check("led_ack",    64'(led_ack),    64'((m_age == X + 1) && m_is_led));
                check("snd_data",   64'(snd_data),   64'(m_snd_data));
                check("pos_x",      64'(pos_x),      64'(m_pos_x));
                check("pos_y",      64'(pos_y),      64'(m_pos_y));
                check("btn",        64'(btn),        64'(m_btn));
                if (snd_rec)    n_rec++;
                if (data_valid) n_dv++;
                if (led_ack)    n_ack++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 snd_rec, 1 data_valid, 2 led_ack. Returns the cycle it was seen in.
    task automatic wait_for(input int which, input int budget, input string name,
                            output int at);
        bit seen;
        seen = 0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((which == 0 && snd_rec) || (which == 1 && data_valid) ||
                (which == 2 && led_ack)) begin
                seen = 1;
                at   = cyc;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: event not seen within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int t, rc, rc2, dc, ac, base_rec, base_ack, base_dv;
        rst = 1'b1; poll_en = 1'b0; led_req = 1'b0; led_val = 2'b00;
        jstk_dout = 40'hA5_3C_5A_01_07;
        repeat (3) step();
        @(negedge clk);
        check("reset busy",     64'(busy),     64'd0);
        check("reset snd_data", 64'(snd_data), 64'h00);
        check("reset pos_x",    64'(pos_x),    64'h000);
        step();
        rst = 1'b0;

        // Periodic polling and DOUT field extraction.
        step();
        poll_en = 1'b1;
        t = cyc;
        wait_for(0, 30, "first poll", rc);
        check("first poll delay", 64'(rc - t), 64'd20);
        wait_for(1, 12, "poll dv", dc);
        check("poll latency", 64'(dc - rc), 64'd9);
        check("poll pos_x",   64'(pos_x),   64'h0A5);
        check("poll pos_y",   64'(pos_y),   64'h15A);
        check("poll btn",     64'(btn),     64'd7);
        check("poll snd_data", 64'(snd_data), 64'h80);
        wait_for(0, 30, "second poll", rc2);
        check("poll period", 64'(rc2 - rc), 64'd20);
        jstk_dout = 40'hA5_3D_5A_03_07;
        wait_for(1, 12, "poll dv 2", dc);
        check("poll pos_x 2", 64'(pos_x), 64'h1A5);
        check("poll pos_y 2", 64'(pos_y), 64'h35A);
        wait_for(0, 30, "third poll", rc);
        check("poll period 2", 64'(rc - rc2), 64'd20);

        // Poll enable dropped for 5 cycles restarts the timer.
        wait_for(1, 12, "dv before pause", dc);
        step();
        poll_en = 1'b0;
        base_rec = n_rec;
        repeat (5) step();
        check("no poll while disabled", 64'(n_rec - base_rec), 64'd0);
        poll_en = 1'b1;
        t = cyc;
        wait_for(0, 30, "poll after pause", rc);
        check("poll restart delay", 64'(rc - t), 64'd20);
        wait_for(1, 12, "dv after pause", dc);
        step();
        poll_en = 1'b0;
        repeat (3) step();

        // Single LED request with polling off.
        base_rec = n_rec;
        led_val = 2'b10;
        led_req = 1'b1;
        t = cyc;
        step();
        led_req = 1'b0;
        wait_for(0, 5, "led start", rc);
        check("led start delay", 64'(rc - t), 64'd1);
        check("led snd_data",    64'(snd_data), 64'h82);
        wait_for(2, 12, "led ack", ac);
        check("led ack latency", 64'(ac - rc), 64'd9);
        repeat (30) step();
        check("led single txn", 64'(n_rec - base_rec), 64'd1);

        // Requests while one is pending are dropped.
        base_rec = n_rec;
        base_ack = n_ack;
        led_val = 2'b01; led_req = 1'b1;
        step();
        led_req = 1'b0;
        repeat (3) step();
        led_val = 2'b10; led_req = 1'b1;
        step();
        led_req = 1'b0;
        step();
        led_val = 2'b11; led_req = 1'b1;
        step();
        led_req = 1'b0;
        repeat (30) step();
        check("drop txn count", 64'(n_rec - base_rec), 64'd2);
        check("drop ack count", 64'(n_ack - base_ack), 64'd2);
        check("drop snd_data",  64'(snd_data),         64'h82);

        // LED request in the cycle the poll timer fires: LED goes first, poll absorbed.
        poll_en = 1'b1;
        t = cyc;
        repeat (19) step();
        base_ack = n_ack;
        led_val = 2'b01; led_req = 1'b1;
        step();
        led_req = 1'b0;
        wait_for(0, 5, "coincident start", rc);
        check("coincident start", 64'(rc - t), 64'd20);
        check("coincident cmd",   64'(snd_data), 64'h81);
        wait_for(2, 12, "coincident ack", ac);
        check("coincident ack", 64'(ac - rc), 64'd9);
        wait_for(0, 30, "next poll", rc2);
        check("next poll period", 64'(rc2 - rc), 64'd20);
        wait_for(1, 12, "next poll dv", dc);
        check("poll no ack", 64'(led_ack), 64'd0);
        check("one led ack", 64'(n_ack - base_ack), 64'd1);

        // Reset in the 4th XFER cycle aborts the transaction.
        wait_for(0, 30, "poll before reset", rc);
        repeat (4) step();
        base_dv = n_dv;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort busy",     64'(busy),     64'd0);
        check("abort snd_data", 64'(snd_data), 64'h00);
        check("abort pos_x",    64'(pos_x),    64'h000);
        check("abort pos_y",    64'(pos_y),    64'h000);
        check("abort btn",      64'(btn),      64'd0);
        repeat (10) step();
        check("abort no dv", 64'(n_dv - base_dv), 64'd0);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
